axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI4 read-channel arbiter.
- Shares the single simulation memory slave read port between the IFU/ICache (M0) and the LSU/DCache (M1).
- Handles one outstanding read transaction at a time. The grant is held from arbitration until the R beat with rlast completes.
- The LSU write channels bypass this block and connect straight to the slave.

Parameters:
- AW, 32, address width.
- DW, 64, data width.
- IDW, 4, ID width.

Ports:
- clock  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m0_arvalid  in  1  IFU read request valid
- m0_arready  out  1  IFU AR accepted
- m0_ar  in  49  IFU AR payload {arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0], araddr[31:0]}
- m0_rvalid  out  1  IFU R beat valid
- m0_rready  in  1  IFU R ready
- m0_r  out  71  IFU R payload {rid[3:0], rresp[1:0], rlast, rdata[63:0]}
- m1_arvalid, m1_arready, m1_ar, m1_rvalid, m1_rready, m1_r: same as M0, for the LSU
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_ar  out  49  slave AR payload
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- s_r  in  71  slave R payload
- arb_err  out  1  one-cycle pulse: rlast arrived on the wrong beat

Behaviour:
- State machine: IDLE, OWN_M0, OWN_M1. Registers: state, ar_done, beat_cnt[7:0], len_q[7:0], last_grant, arb_err.
- Reset values: state=IDLE, ar_done=0, beat_cnt=0, len_q=0, last_grant=M1, arb_err=0.
- All valid/ready outputs decode from state, so they are 0 in IDLE and immediately after reset.
- IDLE:
  - No grant; s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0.
  - If any m*_arvalid, pick a winner (fixed priority: M1 over M0) and go to OWN_x next cycle.
  - Arbitration latency is 1 cycle: the earliest AR handshake is the cycle after the request is seen.
- OWN_x, AR phase (ar_done=0):
  - s_arvalid = mx_arvalid; s_ar = mx_ar; mx_arready = s_arready.
  - On the s_arvalid && s_arready handshake: ar_done<=1, len_q<=arlen, beat_cnt<=0.
  - The payload passes through unregistered and must stay stable per AXI while valid is high.
- OWN_x, R phase:
  - s_rready = mx_rready; mx_rvalid = s_rvalid; mx_r = s_r.
  - Non-owner sees rvalid=0, arready=0, and r = 0.
  - Every s_rvalid && s_rready beat increments beat_cnt.
- Completion: on a beat with rlast=1, go to IDLE, clear ar_done, and set last_grant to the owner.
- Error check:
  - On the rlast beat, if beat_cnt != len_q, assert arb_err for 1 cycle. The transaction still completes.
  - A beat with beat_cnt == len_q but rlast=0 also pulses arb_err; the grant is held until rlast arrives.
- R beats arriving while in IDLE: not accepted (s_rready=0); the slave must hold them.
- An R beat accepted in the same cycle as the AR handshake is legal: count it and evaluate rlast.
- arburst is not interpreted. FIXED single-beat device accesses (arlen=0) and 2-beat INCR cache refills both pass through.
- Owner drops arvalid before its AR handshake (protocol violation): the grant is held; no recovery.
- Reset mid-transaction: forced to IDLE next edge. The slave is expected to be reset by the same rst_n.
- No back-to-back optimisation: at least one IDLE cycle between transactions.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requesting, grant the master not equal to last_grant. With a single requester, grant it.
- Undefined: fixed priority, M1 (LSU) always wins. last_grant is still maintained but unused.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - the ar_t packed struct (49b) and r_t packed struct (71b);
  - state enum {IDLE, OWN_M0, OWN_M1};
  - constants M0=0, M1=1, BURST_FIXED=2'b00, BURST_INCR=2'b01.
- One sub-module, axi_rd_arb_grant: combinational winner select, taking fixed or round-robin under the macro, with inputs req[1:0] and last_grant.
- The top level keeps the FSM, counters and muxes.

Test Plan:
- M0 alone, arlen=1, INCR, addr 0x8000_0010; slave returns beats 0x11, 0x22 (rlast on the 2nd) -> M0 gets both beats in order, M1 rvalid stays 0, back in IDLE 1 cycle after the last beat, arb_err=0.
- M0 and M1 request in the same cycle, reset state -> fixed: M1 first, M0 granted after M1's rlast. Round-robin build: M0 first (last_grant=M1), then M1.
- M1 FIXED arlen=0 read of 0xA000_03F8 while M0 requests mid-transaction -> M0 arready=0 until M1's single rlast beat completes; M0 serviced next.
- rready backpressure: M0 deasserts rready for 3 cycles mid-burst -> s_rready=0 in those cycles, no beat lost, beat_cnt unchanged.
- Slave asserts rlast on beat 0 with arlen=1 -> arb_err pulses 1 cycle and the arbiter returns to IDLE. Separately, arlen=0 with rlast missing -> arb_err pulses and the grant is held until rlast.
- rst_n low during OWN_M1 R phase -> next cycle: state IDLE and all valid/ready outputs 0; the first request after reset arbitrates normally.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI4 read arbiter.
package axi_rd_arb_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   // AR payload, MSB first: {arid, arlen, arsize, arburst, araddr} = 49 bits
   typedef struct packed {
      logic [ID_W-1:0]   arid;
      logic [7:0]        arlen;
      logic [2:0]        arsize;
      logic [1:0]        arburst;
      logic [ADDR_W-1:0] araddr;
   } ar_t;

   // R payload, MSB first: {rid, rresp, rlast, rdata} = 71 bits
   typedef struct packed {
      logic [ID_W-1:0]   rid;
      logic [1:0]        rresp;
      logic              rlast;
      logic [DATA_W-1:0] rdata;
   } r_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_M0 = 2'd1,
      OWN_M1 = 2'd2
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_rd_arb_grant.sv
// Winner select for the read arbiter (combinational).
// Build option ARB_ROUND_ROBIN_EN: with both masters requesting, grant the
// one that did not win last time. Without it, M1 (LSU) always wins.
module axi_rd_arb_grant
   import axi_rd_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

`ifdef ARB_ROUND_ROBIN_EN
   // alternate on contention, otherwise the lone requester wins
   always_comb begin
      grant = M0;
      if (&req)
         grant = ~last_grant;
      else if (req[1])
         grant = M1;
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant             = req[1] ? M1 : M0;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read-channel arbiter, one transaction in flight.
// The grant is held from arbitration until the rlast beat completes; all
// handshake signals decode from the state, payloads pass through unregistered.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of M1 priority.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int AW  = 32,
   parameter int DW  = 64,
   parameter int IDW = 4,
   localparam int ARW = IDW + 8 + 3 + 2 + AW,
   localparam int RW  = IDW + 2 + 1 + DW
) (
   input  logic           clock,
   input  logic           rst_n,
   input  logic           m0_arvalid,
   output logic           m0_arready,
   input  logic [ARW-1:0] m0_ar,
   output logic           m0_rvalid,
   input  logic           m0_rready,
   output logic [RW-1:0]  m0_r,
   input  logic           m1_arvalid,
   output logic           m1_arready,
   input  logic [ARW-1:0] m1_ar,
   output logic           m1_rvalid,
   input  logic           m1_rready,
   output logic [RW-1:0]  m1_r,
   output logic           s_arvalid,
   input  logic           s_arready,
   output logic [ARW-1:0] s_ar,
   input  logic           s_rvalid,
   output logic           s_rready,
   input  logic [RW-1:0]  s_r,
   output logic           arb_err
);

   state_t         state;
   logic           ar_done;
   logic [7:0]     beat_cnt;
   logic [7:0]     len_q;
   logic           last_grant;

   logic           grant;
   logic           own0, own1, owned;
   logic           own_arvalid, own_rready;
   logic [ARW-1:0] own_ar;
   logic           ar_hs, r_hs;
   logic [7:0]     cur_idx, cur_len;

   axi_rd_arb_grant u_grant (
      .req        ({m1_arvalid, m0_arvalid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign own0  = (state == OWN_M0);
   assign own1  = (state == OWN_M1);
   assign owned = own0 | own1;

   assign own_arvalid = own1 ? m1_arvalid : m0_arvalid;
   assign own_ar      = own1 ? m1_ar      : m0_ar;
   assign own_rready  = own1 ? m1_rready  : m0_rready;

   // AR channel: open only to the owner, and only until its handshake
   assign s_arvalid  = owned & ~ar_done & own_arvalid;
   assign s_ar       = owned ? own_ar : '0;
   assign m0_arready = own0 & ~ar_done & s_arready;
   assign m1_arready = own1 & ~ar_done & s_arready;

   // R channel: open from grant on, so a beat in the AR handshake cycle is legal
   assign s_rready  = owned & own_rready;
   assign m0_rvalid = own0 & s_rvalid;
   assign m1_rvalid = own1 & s_rvalid;
   assign m0_r      = own0 ? s_r : '0;
   assign m1_r      = own1 ? s_r : '0;

   assign ar_hs = s_arvalid & s_arready;
   assign r_hs  = s_rvalid & s_rready;

   // a beat coinciding with the AR handshake is beat 0 of the new arlen
   assign cur_idx = ar_hs ? 8'd0 : beat_cnt;
   assign cur_len = ar_hs ? s_ar[AW+5 +: 8] : len_q;

   // arbitration FSM with beat counting and the rlast consistency check
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state      <= IDLE;
         ar_done    <= 1'b0;
         beat_cnt   <= 8'd0;
         len_q      <= 8'd0;
         last_grant <= M1;
         arb_err    <= 1'b0;
      end else begin
         arb_err <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_arvalid | m1_arvalid)
                  state <= (grant == M1) ? OWN_M1 : OWN_M0;
            end
            default: begin
               if (ar_hs) begin
                  ar_done  <= 1'b1;
                  len_q    <= s_ar[AW+5 +: 8];
                  beat_cnt <= 8'd0;
               end
               if (r_hs) begin
                  beat_cnt <= cur_idx + 8'd1;
                  if (s_r[DW]) begin
                     state      <= IDLE;
                     ar_done    <= 1'b0;
                     last_grant <= own1 ? M1 : M0;
                     arb_err    <= (cur_idx != cur_len);
                  end else begin
                     arb_err    <= (cur_idx == cur_len);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: behavioural slave, master tasks and
// a transaction-level model of grant order and returned beats.
module tb_axi_rd_arbiter;
   import axi_rd_arb_pkg::*;

   logic clock = 1'b0;
   logic rst_n;
   always #5 clock = ~clock;

   ar_t  m0_ar, m1_ar, s_ar;
   r_t   m0_r, m1_r, s_r;
   logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic s_arvalid, s_arready, s_rvalid, s_rready, arb_err;

   // master-side drives and observations, indexed by master number
   logic arv_d[2], rr_d[2];
   ar_t  ar_d[2];
   logic arr_w[2], rv_w[2];
   r_t   r_w[2];
   assign m0_arvalid = arv_d[0];
   assign m1_arvalid = arv_d[1];
   assign m0_ar = ar_d[0];
   assign m1_ar = ar_d[1];
   assign m0_rready = rr_d[0];
   assign m1_rready = rr_d[1];
   assign arr_w[0] = m0_arready;
   assign arr_w[1] = m1_arready;
   assign rv_w[0] = m0_rvalid;
   assign rv_w[1] = m1_rvalid;
   assign r_w[0] = m0_r;
   assign r_w[1] = m1_r;

   axi_rd_arbiter dut (
      .clock(clock), .rst_n(rst_n),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
      .arb_err(arb_err)
   );

   int total = 0, bad = 0;
   int cyc = 0;
   int ar_prob = 100, rv_prob = 100, err_mode = 0;
   int ar_cyc[2], done_cyc[2], start_cyc[2];
   bit tmo[2];
   bit rx_active[2];
   r_t rx_q[2][$];
   int err_cnt = 0, leak = 0, bp_viol = 0, bp_low = 0;
   bit mon_en = 1'b0;
   bit mdl_last = M1;   // model of the last completed owner

   // slave data pattern; mode 1 ends on beat 0, mode 2 one beat late
   function automatic r_t exp_beat(ar_t a, int i, int mode);
      r_t r;
      r.rid   = a.arid;
      r.rresp = 2'b00;
      r.rdata = {a.araddr ^ 32'hC0DE_0000, 24'h0, 8'(i)};
      case (mode)
         1:       r.rlast = (i == 0);
         2:       r.rlast = (i == int'(a.arlen) + 1);
         default: r.rlast = (i == int'(a.arlen));
      endcase
      return r;
   endfunction

   function automatic int exp_nbeat(ar_t a, int mode);
      if (mode == 1) return 1;
      if (mode == 2) return int'(a.arlen) + 2;
      return int'(a.arlen) + 1;
   endfunction

   function automatic int exp_first();
`ifdef ARB_ROUND_ROBIN_EN
      return mdl_last ? 0 : 1;
`else
      return 1;
`endif
   endfunction

   function automatic ar_t mk_ar(logic [31:0] addr, logic [7:0] len, logic [1:0] burst);
      ar_t a;
      a.arid = 4'($urandom);
      a.arlen = len;
      a.arsize = 3'd3;
      a.arburst = burst;
      a.araddr = addr;
      return a;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // monitor: error pulses and R traffic reaching a master outside its R phase
   always @(negedge clock) begin
      if (arb_err === 1'b1) err_cnt++;
      if (mon_en)
         for (int m = 0; m < 2; m++)
            if (!rx_active[m] && (rv_w[m] !== 1'b0 || r_w[m] !== '0)) leak++;
   end

   // behavioural slave: one burst at a time, holds rvalid until accepted
   initial begin : slave
      ar_t sl_ar, sar;
      int  sl_beat, sl_mode;
      bit  sl_act, arh, rh, rs;
      s_arready = 1'b0; s_rvalid = 1'b0; s_r = '0;
      sl_act = 0; sl_beat = 0; sl_mode = 0; sl_ar = '0;
      forever begin
         @(negedge clock);
         arh = (s_arvalid === 1'b1) && s_arready;
         rh  = s_rvalid && (s_rready === 1'b1);
         rs  = rst_n;
         sar = s_ar;
         @(posedge clock); #1;
         if (!rs) begin
            sl_act = 0; s_rvalid = 1'b0; s_r = '0;
         end else begin
            if (rh) begin
               if (s_r.rlast) sl_act = 0;
               else sl_beat++;
            end
            if (arh) begin
               sl_act = 1; sl_ar = sar; sl_beat = 0; sl_mode = err_mode;
            end
            if (rh || !s_rvalid) begin
               if (sl_act && $urandom_range(99) < rv_prob) begin
                  s_rvalid = 1'b1; s_r = exp_beat(sl_ar, sl_beat, sl_mode);
               end else begin
                  s_rvalid = 1'b0; s_r = '0;
               end
            end
         end
         s_arready = ($urandom_range(99) < ar_prob);
      end
   end

   task automatic clr();
      for (int m = 0; m < 2; m++) begin
         rx_q[m].delete(); tmo[m] = 0; ar_cyc[m] = 0; done_cyc[m] = 0; start_cyc[m] = 0;
      end
      err_cnt = 0; leak = 0; bp_viol = 0; bp_low = 0; err_mode = 0;
   endtask

   // one read from master m; rready held low 3 cycles once lo_at beats arrived
   task automatic m_read(input int m, input ar_t a, input bit rnd, input int lo_at);
      int t, nbeat, lo_left;
      bit hs, last, got;
      r_t rb;
      ar_d[m] = a; arv_d[m] = 1'b1; start_cyc[m] = cyc;
      t = 0; hs = 0;
      while (!hs && t < 400) begin
         @(negedge clock);
         hs = (arr_w[m] === 1'b1);
         @(posedge clock); #1; t++;
      end
      arv_d[m] = 1'b0; ar_d[m] = '0;
      if (!hs) begin tmo[m] = 1; return; end
      ar_cyc[m] = cyc; rx_active[m] = 1;
      last = 0; t = 0; nbeat = 0;
      lo_left = (lo_at == 0) ? 3 : 0;
      while (!last && t < 400) begin
         if (lo_left > 0) begin rr_d[m] = 1'b0; lo_left--; bp_low++; end
         else rr_d[m] = rnd ? 1'($urandom_range(1)) : 1'b1;
         @(negedge clock);
         if (!rr_d[m] && s_rready !== 1'b0) bp_viol++;
         got = (rv_w[m] === 1'b1) && rr_d[m];
         rb = r_w[m];
         @(posedge clock); #1; t++;
         if (got) begin
            rx_q[m].push_back(rb); nbeat++; last = rb.rlast;
            if (nbeat == lo_at) lo_left = 3;
         end
      end
      rr_d[m] = 1'b0; rx_active[m] = 0; done_cyc[m] = cyc;
      if (!last) tmo[m] = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      arv_d[0] = 1'b1; arv_d[1] = 1'b1;
      ar_d[0] = mk_ar(32'h1000, 8'd0, BURST_INCR); ar_d[1] = mk_ar(32'h2000, 8'd0, BURST_INCR);
      rr_d[0] = 1'b1; rr_d[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++;
         if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, arb_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, arb_err});
         end
      end
      @(posedge clock); #1;
      arv_d[0] = 1'b0; arv_d[1] = 1'b0; rr_d[0] = 1'b0; rr_d[1] = 1'b0;
      ar_d[0] = '0; ar_d[1] = '0;
      rst_n = 1'b1; mdl_last = M1; mon_en = 1'b1;
   endtask

   task automatic test_single_m0();
      ar_t a0, a1;
      clr(); ar_prob = 100; rv_prob = 100;
      a0 = mk_ar(32'h8000_0010, 8'd1, BURST_INCR);
      a1 = mk_ar(32'($urandom), 8'd0, BURST_FIXED);
      m_read(0, a0, 0, -1);
      m_read(1, a1, 0, -1);
      total++; if (ar_cyc[0] - start_cyc[0] !== 2) begin bad++; $display("FAIL single_ar_latency: got %0d want 2", ar_cyc[0] - start_cyc[0]); end
      total++; if (rx_q[0].size() !== 2) begin bad++; $display("FAIL single_nbeat: got %0d want 2", rx_q[0].size()); end
      for (int i = 0; i < rx_q[0].size(); i++) begin
         total++; if (rx_q[0][i] !== exp_beat(a0, i, 0)) begin bad++; $display("FAIL single_beat%0d: got %h want %h", i, rx_q[0][i], exp_beat(a0, i, 0)); end
      end
      total++; if (ar_cyc[1] - done_cyc[0] !== 2) begin bad++; $display("FAIL single_idle_gap: got %0d want 2", ar_cyc[1] - done_cyc[0]); end
      total++; if (rx_q[1].size() !== 1 || rx_q[1][0] !== exp_beat(a1, 0, 0)) begin bad++; $display("FAIL single_follow_m1: got n=%0d want 1 matching beat", rx_q[1].size()); end
      total++; if ({err_cnt, leak} !== {32'd0, 32'd0}) begin bad++; $display("FAIL single_err_leak: got err=%0d leak=%0d want 0 0", err_cnt, leak); end
      total++; if ({tmo[0], tmo[1]} !== 2'b00) begin bad++; $display("FAIL single_timeout: got %b want 00", {tmo[0], tmo[1]}); end
      mdl_last = M1;
   endtask

   task automatic test_contention();
      ar_t a[2];
      int f, s;
      clr(); ar_prob = 100; rv_prob = 100;
      a[0] = mk_ar(32'($urandom), 8'd1, BURST_INCR);
      a[1] = mk_ar(32'($urandom), 8'd1, BURST_INCR);
      f = exp_first(); s = 1 - f;
      fork
         m_read(0, a[0], 0, -1);
         m_read(1, a[1], 0, -1);
      join
      total++; if (ar_cyc[f] - start_cyc[f] !== 2) begin bad++; $display("FAIL cont_first_latency: m%0d got %0d want 2", f, ar_cyc[f] - start_cyc[f]); end
      total++; if (ar_cyc[s] - done_cyc[f] !== 2) begin bad++; $display("FAIL cont_second_after_rlast: m%0d got %0d want 2", s, ar_cyc[s] - done_cyc[f]); end
      for (int m = 0; m < 2; m++) begin
         total++; if (rx_q[m].size() !== 2) begin bad++; $display("FAIL cont_nbeat_m%0d: got %0d want 2", m, rx_q[m].size()); end
         for (int i = 0; i < rx_q[m].size(); i++) begin
            total++; if (rx_q[m][i] !== exp_beat(a[m], i, 0)) begin bad++; $display("FAIL cont_beat_m%0d_%0d: got %h want %h", m, i, rx_q[m][i], exp_beat(a[m], i, 0)); end
         end
      end
      total++; if ({err_cnt, leak, 30'd0, tmo[0], tmo[1]} !== 96'd0) begin bad++; $display("FAIL cont_misc: err=%0d leak=%0d tmo=%b%b want 0", err_cnt, leak, tmo[0], tmo[1]); end
      mdl_last = 1'(s);
   endtask

   task automatic test_mid_request();
      ar_t a0, a1;
      clr(); ar_prob = 100; rv_prob = 100;
      a1 = mk_ar(32'hA000_03F8, 8'd0, BURST_FIXED);
      a0 = mk_ar(32'($urandom), 8'd1, BURST_INCR);
      fork
         m_read(1, a1, 0, 0);
         begin repeat (3) @(posedge clock); #1; m_read(0, a0, 0, -1); end
      join
      total++; if (!(start_cyc[0] < done_cyc[1])) begin bad++; $display("FAIL mid_req_overlap: m0 start %0d m1 done %0d want start<done", start_cyc[0], done_cyc[1]); end
      total++; if (ar_cyc[0] - done_cyc[1] !== 2) begin bad++; $display("FAIL mid_m0_after_m1: got %0d want 2", ar_cyc[0] - done_cyc[1]); end
      total++; if (rx_q[1].size() !== 1 || rx_q[1][0] !== exp_beat(a1, 0, 0)) begin bad++; $display("FAIL mid_m1_beat: got n=%0d want 1 matching beat", rx_q[1].size()); end
      total++; if (rx_q[0].size() !== 2) begin bad++; $display("FAIL mid_m0_nbeat: got %0d want 2", rx_q[0].size()); end
      for (int i = 0; i < rx_q[0].size(); i++) begin
         total++; if (rx_q[0][i] !== exp_beat(a0, i, 0)) begin bad++; $display("FAIL mid_m0_beat%0d: got %h want %h", i, rx_q[0][i], exp_beat(a0, i, 0)); end
      end
      total++; if ({err_cnt, leak, bp_viol} !== 96'd0) begin bad++; $display("FAIL mid_misc: err=%0d leak=%0d bp=%0d want 0", err_cnt, leak, bp_viol); end
      mdl_last = M0;
   endtask

   task automatic test_backpressure();
      ar_t a;
      clr(); ar_prob = 100; rv_prob = 100;
      a = mk_ar(32'($urandom), 8'd3, BURST_INCR);
      m_read(0, a, 0, 1);
      total++; if (bp_low !== 3) begin bad++; $display("FAIL bp_low_cycles: got %0d want 3", bp_low); end
      total++; if (bp_viol !== 0) begin bad++; $display("FAIL bp_s_rready: got %0d violations want 0", bp_viol); end
      total++; if (rx_q[0].size() !== 4) begin bad++; $display("FAIL bp_nbeat: got %0d want 4", rx_q[0].size()); end
      for (int i = 0; i < rx_q[0].size(); i++) begin
         total++; if (rx_q[0][i] !== exp_beat(a, i, 0)) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_q[0][i], exp_beat(a, i, 0)); end
      end
      total++; if ({err_cnt, leak, 31'd0, tmo[0]} !== 96'd0) begin bad++; $display("FAIL bp_misc: err=%0d leak=%0d tmo=%b want 0", err_cnt, leak, tmo[0]); end
      mdl_last = M0;
   endtask

   task automatic test_rlast_err();
      ar_t a0, a1, b0;
      // early rlast on beat 0 of a 2-beat burst
      clr(); ar_prob = 100; rv_prob = 100; err_mode = 1;
      a0 = mk_ar(32'($urandom), 8'd1, BURST_INCR);
      m_read(0, a0, 0, -1);
      err_mode = 0;
      a1 = mk_ar(32'($urandom), 8'd0, BURST_FIXED);
      m_read(1, a1, 0, -1);
      total++; if (err_cnt !== 1) begin bad++; $display("FAIL early_rlast_pulses: got %0d want 1", err_cnt); end
      total++; if (rx_q[0].size() !== 1 || rx_q[0][0] !== exp_beat(a0, 0, 1)) begin bad++; $display("FAIL early_rlast_beat: got n=%0d want 1 matching beat", rx_q[0].size()); end
      total++; if (ar_cyc[1] - done_cyc[0] !== 2) begin bad++; $display("FAIL early_rlast_idle: got %0d want 2", ar_cyc[1] - done_cyc[0]); end
      // missing rlast on a single-beat read: grant held until the late rlast
      clr(); ar_prob = 100; rv_prob = 100; err_mode = 2;
      a1 = mk_ar(32'($urandom), 8'd0, BURST_FIXED);
      b0 = mk_ar(32'($urandom), 8'd0, BURST_INCR);
      fork
         m_read(1, a1, 0, 0);
         begin repeat (3) @(posedge clock); #1; err_mode = 0; m_read(0, b0, 0, -1); end
      join
      total++; if (err_cnt !== 2) begin bad++; $display("FAIL late_rlast_pulses: got %0d want 2", err_cnt); end
      total++; if (rx_q[1].size() !== 2) begin bad++; $display("FAIL late_rlast_nbeat: got %0d want 2", rx_q[1].size()); end
      for (int i = 0; i < rx_q[1].size(); i++) begin
         total++; if (rx_q[1][i] !== exp_beat(a1, i, 2)) begin bad++; $display("FAIL late_rlast_beat%0d: got %h want %h", i, rx_q[1][i], exp_beat(a1, i, 2)); end
      end
      total++; if (ar_cyc[0] - done_cyc[1] !== 2) begin bad++; $display("FAIL late_rlast_hold: got %0d want 2", ar_cyc[0] - done_cyc[1]); end
      total++; if (rx_q[0].size() !== 1 || rx_q[0][0] !== exp_beat(b0, 0, 0)) begin bad++; $display("FAIL late_rlast_next: got n=%0d want 1 matching beat", rx_q[0].size()); end
      total++; if (leak !== 0) begin bad++; $display("FAIL err_leak: got %0d want 0", leak); end
      mdl_last = M0;
   endtask

   task automatic test_reset_mid();
      ar_t a;
      int t;
      bit hs;
      clr(); ar_prob = 100; rv_prob = 100; mon_en = 1'b0;
      a = mk_ar(32'($urandom), 8'd7, BURST_INCR);
      ar_d[1] = a; arv_d[1] = 1'b1; rr_d[1] = 1'b1;
      t = 0; hs = 0;
      while (!hs && t < 50) begin
         @(negedge clock); hs = (m1_arready === 1'b1);
         @(posedge clock); #1; t++;
      end
      arv_d[1] = 1'b0; ar_d[1] = '0;
      total++; if (hs !== 1'b1) begin bad++; $display("FAIL rstmid_ar: got hs=%b want 1", hs); end
      repeat (2) @(posedge clock); #1;
      rst_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      total++;
      if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0 || m1_r !== '0) begin
         bad++; $display("FAIL rstmid_outputs: got %b r=%h want 0", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, m1_r);
      end
      @(posedge clock); #1;
      rst_n = 1'b1; rr_d[1] = 1'b0; mdl_last = M1;
      @(posedge clock); #1;
      clr(); mon_en = 1'b1;
      a = mk_ar(32'($urandom), 8'd1, BURST_INCR);
      m_read(0, a, 0, -1);
      total++; if (ar_cyc[0] - start_cyc[0] !== 2) begin bad++; $display("FAIL rstmid_rearb: got %0d want 2", ar_cyc[0] - start_cyc[0]); end
      total++; if (rx_q[0].size() !== 2 || rx_q[0][0] !== exp_beat(a, 0, 0) || rx_q[0][1] !== exp_beat(a, 1, 0)) begin
         bad++; $display("FAIL rstmid_data: got n=%0d want 2 matching beats", rx_q[0].size());
      end
      total++; if ({err_cnt, leak} !== 64'd0) begin bad++; $display("FAIL rstmid_misc: err=%0d leak=%0d want 0", err_cnt, leak); end
      mdl_last = M0;
   endtask

   task automatic test_random();
      ar_t a[2];
      int f, s;
      bit both;
      for (int n = 0; n < 16; n++) begin
         clr();
         ar_prob = $urandom_range(30, 100); rv_prob = $urandom_range(30, 100);
         for (int m = 0; m < 2; m++)
            a[m] = mk_ar(32'($urandom), 8'($urandom_range(0, 5)), $urandom_range(1) ? BURST_INCR : BURST_FIXED);
         both = 1'($urandom_range(1));
         if (both) begin
            f = exp_first(); s = 1 - f;
            fork
               m_read(0, a[0], 1, -1);
               m_read(1, a[1], 1, -1);
            join
            total++; if (!(ar_cyc[s] - done_cyc[f] >= 2)) begin bad++; $display("FAIL rnd%0d_order: m%0d ar %0d first done %0d", n, s, ar_cyc[s], done_cyc[f]); end
            mdl_last = 1'(s);
         end else begin
            f = $urandom_range(1);
            m_read(f, a[f], 1, -1);
            mdl_last = 1'(f);
         end
         for (int m = 0; m < 2; m++) begin
            if (both || m == f) begin
               total++; if (rx_q[m].size() !== exp_nbeat(a[m], 0)) begin bad++; $display("FAIL rnd%0d_nbeat_m%0d: got %0d want %0d", n, m, rx_q[m].size(), exp_nbeat(a[m], 0)); end
               for (int i = 0; i < rx_q[m].size(); i++) begin
                  total++; if (rx_q[m][i] !== exp_beat(a[m], i, 0)) begin bad++; $display("FAIL rnd%0d_beat_m%0d_%0d: got %h want %h", n, m, i, rx_q[m][i], exp_beat(a[m], i, 0)); end
               end
            end
         end
         total++; if ({err_cnt, leak, bp_viol, 30'd0, tmo[0], tmo[1]} !== 128'd0) begin
            bad++; $display("FAIL rnd%0d_misc: err=%0d leak=%0d bp=%0d tmo=%b%b want 0", n, err_cnt, leak, bp_viol, tmo[0], tmo[1]);
         end
      end
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int m = 0; m < 2; m++) begin arv_d[m] = 1'b0; rr_d[m] = 1'b0; ar_d[m] = '0; rx_active[m] = 0; end
      test_reset();
      test_single_m0();
      test_contention();
      test_mid_request();
      test_backpressure();
      test_rlast_err();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
